// File: rtl/deserializer_rx.sv
// Receive side of the pixel-chip serial readout link: frames MSB-first words from a
// start strobe, holds them for the DAQ behind a valid/ready handshake, tracks link status.
module deserializer_rx #(
  parameter int               WIDTH        = 27,
  parameter logic [WIDTH-1:0] TEST_PATTERN = 27'h4AACC0F,
  parameter int               DELAY_BITS   = 4
) (
  input  logic                  ClkOut,
  input  logic                  RstN,
  input  logic                  Start,
  input  logic                  SerIn,
  input  logic [DELAY_BITS-1:0] Delay,
  input  logic                  EnTestPattern,
  input  logic                  ClearCnt,
  output logic [WIDTH-1:0]      DataOut,
  output logic                  Valid,
  input  logic                  Ready,
  output logic                  Busy,
  output logic                  Overflow,
  output logic                  FrameErr,
  output logic [7:0]            ErrCnt,
  output logic [15:0]           WordCnt,
  output logic [1:0]            StateDbg
);

  // Handshake: a word transfers on every rising edge where Valid and Ready are both high;
  // Valid stays high with DataOut stable until that edge.

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e                state_q;
  logic [DELAY_BITS-1:0] delay_q;
  logic [CNT_W-1:0]      bit_q;
  logic [WIDTH-2:0]      sr_q;
  logic [WIDTH-1:0]      data_q;
  logic                  valid_q;
  logic                  overflow_q;
  logic                  frame_err_q;
  logic [7:0]            err_cnt_q;
  logic [15:0]           word_cnt_q;

  logic [WIDTH-1:0]      word_d;
  logic                  commit_d;
  logic                  accept_d;
  logic                  mismatch_d;
  logic                  busy_d;

  assign word_d     = {sr_q, SerIn};
  assign commit_d   = (state_q == SHIFT) && (bit_q == '0);
  assign accept_d   = !valid_q || Ready;
  assign mismatch_d = EnTestPattern && (word_d != TEST_PATTERN);
  assign busy_d     = (state_q != IDLE);

  always_ff @(posedge ClkOut or negedge RstN) begin
    if (!RstN) begin
      state_q     <= IDLE;
      delay_q     <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            delay_q <= Delay;
            if (Delay != '0) begin
              state_q <= WAIT;
            end else begin
              state_q <= SHIFT;
              bit_q   <= CNT_W'(WIDTH - 1);
            end
          end
        end
        WAIT: begin
          delay_q <= delay_q - DELAY_BITS'(1);
          if (delay_q == DELAY_BITS'(1)) begin
            state_q <= SHIFT;
            bit_q   <= CNT_W'(WIDTH - 1);
          end
        end
        SHIFT: begin
          sr_q  <= {sr_q[WIDTH-3:0], SerIn};
          bit_q <= bit_q - CNT_W'(1);
          if (bit_q == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A commit wins over the same-edge handshake so Valid stays high for the new word.
      if (commit_d && accept_d) begin
        data_q  <= word_d;
        valid_q <= 1'b1;
      end else if (valid_q && Ready) begin
        valid_q <= 1'b0;
      end

      if (ClearCnt) begin
        overflow_q  <= 1'b0;
        frame_err_q <= 1'b0;
        err_cnt_q   <= '0;
        word_cnt_q  <= '0;
      end else begin
        if (commit_d) begin
          word_cnt_q <= word_cnt_q + 16'd1;
          if (!accept_d) overflow_q <= 1'b1;
          if (mismatch_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
        if (Start && busy_d) frame_err_q <= 1'b1;
      end
    end
  end

  assign DataOut  = data_q;
  assign Valid    = valid_q;
  assign Busy     = busy_d;
  assign Overflow = overflow_q;
  assign FrameErr = frame_err_q;
  assign ErrCnt   = err_cnt_q;
  assign WordCnt  = word_cnt_q;
  assign StateDbg = state_q;

endmodule

// File: tb/tb_deserializer_rx.sv
// Bench for deserializer_rx: a serial driver task, an expected-word queue popped by a
// handshake monitor, and directed status checks.
module tb_deserializer_rx;

  localparam int               WIDTH = 27;
  localparam logic [WIDTH-1:0] TP    = 27'h4AACC0F;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ser_in;
  logic [3:0]       delay;
  logic             en_tp;
  logic             clear_cnt;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             ready;
  logic             busy;
  logic             overflow;
  logic             frame_err;
  logic [7:0]       err_cnt;
  logic [15:0]      word_cnt;
  logic [1:0]       state_dbg;

  int n_pass = 0;
  int n_total = 0;
  logic [WIDTH-1:0] exp_q[$];

  deserializer_rx #(.WIDTH(WIDTH), .TEST_PATTERN(TP), .DELAY_BITS(4)) dut (
    .ClkOut(clk), .RstN(rst_n), .Start(start), .SerIn(ser_in), .Delay(delay),
    .EnTestPattern(en_tp), .ClearCnt(clear_cnt), .DataOut(data_out), .Valid(valid),
    .Ready(ready), .Busy(busy), .Overflow(overflow), .FrameErr(frame_err),
    .ErrCnt(err_cnt), .WordCnt(word_cnt), .StateDbg(state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame: Start sampled on the first edge, Delay idle edges, then 27 bits MSB first.
  task automatic send_frame(input logic [WIDTH-1:0] w, input logic [3:0] d, input bit push,
                            input bit mid_start, input bit ready_last, input int abort_bit);
    if (push) exp_q.push_back(w);
    start = 1'b1;
    delay = d;
    step();
    start = 1'b0;
    repeat (d) step();
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i == abort_bit) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        return;
      end
      ser_in = w[i];
      start  = mid_start && (i == 13);
      if (mid_start && (i == 13)) check("busy_mid_frame", {31'd0, busy}, 32'd1);
      if (ready_last && (i == 0)) ready = 1'b1;
      step();
    end
    start = 1'b0;
  endtask

  // monitor: a handshake at the next edge is visible here, half a cycle ahead
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got 0x%0h with no word expected", data_out);
      end else begin
        check("data_out", {5'd0, data_out}, {5'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; ser_in = 1'b0; delay = '0;
    en_tp = 1'b0; clear_cnt = 1'b0; ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_data_out", {5'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // Delay 0, basic word
    repeat (6) step();
    send_frame(27'h5A5A5A5, 4'd0, 1'b1, 1'b0, 1'b0, -1);
    check("d0_valid", {31'd0, valid}, 32'd1);
    check("d0_busy_after", {31'd0, busy}, 32'd0);
    check("d0_word_cnt", {16'd0, word_cnt}, 32'd1);

    // Delay 3 with pattern checking
    en_tp = 1'b1;
    send_frame(TP, 4'd3, 1'b1, 1'b0, 1'b0, -1);
    send_frame(27'h4AACC0E, 4'd3, 1'b1, 1'b0, 1'b0, -1);
    step();
    check("tp_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("tp_word_cnt", {16'd0, word_cnt}, 32'd3);

    // overflow: consumer stalled over two back-to-back frames
    en_tp = 1'b0;
    ready = 1'b0;
    send_frame(27'h1234567, 4'd0, 1'b1, 1'b0, 1'b0, -1);
    send_frame(27'h7654321, 4'd0, 1'b0, 1'b0, 1'b0, -1);
    check("ovf_data_held", {5'd0, data_out}, 32'h1234567);
    check("ovf_valid", {31'd0, valid}, 32'd1);
    check("ovf_overflow", {31'd0, overflow}, 32'd1);
    check("ovf_word_cnt", {16'd0, word_cnt}, 32'd5);
    ready = 1'b1;
    step();
    check("ovf_valid_drop", {31'd0, valid}, 32'd0);
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    check("clr_overflow", {31'd0, overflow}, 32'd0);
    check("clr_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("clr_err_cnt", {24'd0, err_cnt}, 32'd0);

    // handshake coincides with the next commit
    ready = 1'b0;
    send_frame(27'h0ABCDEF, 4'd0, 1'b1, 1'b0, 1'b0, -1);
    send_frame(27'h3C3C3C3, 4'd1, 1'b1, 1'b0, 1'b1, -1);
    check("pend_valid", {31'd0, valid}, 32'd1);
    check("pend_data", {5'd0, data_out}, 32'h3C3C3C3);
    check("pend_overflow", {31'd0, overflow}, 32'd0);
    step();
    check("pend_word_cnt", {16'd0, word_cnt}, 32'd2);

    // Start inside a frame
    send_frame(27'h6DB6DB6, 4'd0, 1'b1, 1'b1, 1'b0, -1);
    check("ferr_flag", {31'd0, frame_err}, 32'd1);
    check("ferr_word_cnt", {16'd0, word_cnt}, 32'd3);
    repeat (5) step();
    check("ferr_no_extra", {31'd0, valid}, 32'd0);

    // reset mid-frame, then a fresh frame
    send_frame(27'h5555555, 4'd0, 1'b0, 1'b0, 1'b0, 10);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("abort_frame_err", {31'd0, frame_err}, 32'd0);
    check("abort_state", {30'd0, state_dbg}, 32'd0);
    send_frame(27'h2222222, 4'd2, 1'b1, 1'b0, 1'b0, -1);
    check("after_abort_word_cnt", {16'd0, word_cnt}, 32'd1);
    check("after_abort_data", {5'd0, data_out}, 32'h2222222);

    // error counter saturation
    en_tp = 1'b1;
    for (int k = 0; k < 300; k++)
      send_frame(27'h0000100 + 27'(k), 4'd0, 1'b1, 1'b0, 1'b0, -1);
    step();
    check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    check("sat_word_cnt", {16'd0, word_cnt}, 32'd301);

    repeat (4) step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
